// File: rtl/led_ctrl_pkg.sv
// rtl/led_ctrl_pkg.sv - shared widths, end positions and press FSM states for the LED bounce controller
package led_ctrl_pkg;

  localparam int SPEED_W = 2;
  localparam int POS_W   = 3;

  localparam logic [POS_W-1:0] POS_MIN = 3'd0;
  localparam logic [POS_W-1:0] POS_MAX = 3'd7;

  // Press FSM encoding kept as plain constants so older tools can consume it
  typedef logic [1:0] press_state_t;
  localparam press_state_t ST_IDLE      = 2'd0;
  localparam press_state_t ST_PRESSED   = 2'd1;
  localparam press_state_t ST_LONG_HELD = 2'd2;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronizer plus stability counter for a raw push button
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Adopt the new level only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (sync2 == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt    <= '0;
      btn_db <= sync2;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_bounce_ctrl.sv
// rtl/led_bounce_ctrl.sv - button-driven run/speed control and step/direction strobes for the 8-LED bounce counter
module led_bounce_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 8,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter int TICK_BASE         = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push_button,
  input  logic [POS_W-1:0]   pos,
  output logic               step_en,
  output logic               dir_up,
  output logic               run,
  output logic [SPEED_W-1:0] speed_sel
);

  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam int TICK_W = $clog2(TICK_BASE * 8 + 1);

  logic              btn_db;
  press_state_t      state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] period;
  logic              tick_wrap;
  logic              short_act;
  logic              long_act;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_raw(push_button),
    .btn_db (btn_db)
  );

  // Actions fire on the edge that leaves PRESSED; long fires as the hold count reaches its limit
  always_comb begin
    short_act = 1'b0;
    long_act  = 1'b0;
    if (state == ST_PRESSED) begin
      if (!btn_db) begin
        short_act = 1'b1;
      end else if (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 2)) begin
        long_act = 1'b1;
      end
    end
  end

  // Press classification FSM on the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_db) begin
            state    <= ST_PRESSED;
            hold_cnt <= '0;
          end
        end
        ST_PRESSED: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          if (short_act) begin
            state <= ST_IDLE;
          end else if (long_act) begin
            state <= ST_LONG_HELD;
          end
        end
        ST_LONG_HELD: begin
          if (!btn_db) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Short press toggles run, long press advances the speed with wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      speed_sel <= '0;
    end else begin
      if (short_act) begin
        run <= ~run;
      end
      if (long_act) begin
        speed_sel <= speed_sel + SPEED_W'(1);
      end
    end
  end

  assign period    = TICK_W'(TICK_BASE) << speed_sel;
  assign tick_wrap = (tick_cnt == period - TICK_W'(1));

  // Step tick: a speed change restarts the period and suppresses a coincident strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      step_en  <= 1'b0;
    end else if (long_act || !run) begin
      tick_cnt <= '0;
      step_en  <= 1'b0;
    end else begin
      step_en  <= tick_wrap;
      tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  // Reverse at the end positions reported back by the counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_up <= 1'b1;
    end else if (pos == POS_MAX) begin
      dir_up <= 1'b0;
    end else if (pos == POS_MIN) begin
      dir_up <= 1'b1;
    end
  end

endmodule
